// File: rtl/conv_frame_loader.sv
// conv_frame_loader: packs a valid/ready pixel stream into ROW_PIX-wide row
// words, writes NUM_ROWS rows into the input RAM, then kicks the convolution
// core and waits for it to finish.
// Optional build macro: CONV_LOADER_CHECKSUM_EN enables the pix_sum accumulator.
module conv_frame_loader #(
    parameter int PIX_W    = 8,
    parameter int ROW_PIX  = 128,
    parameter int NUM_ROWS = 128,
    parameter int ADDR_W   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     pix_valid,
    input  logic [PIX_W-1:0]         pix_data,
    output logic                     pix_ready,
    output logic                     ram_en,
    output logic                     ram_we,
    output logic [ADDR_W-1:0]        ram_addr,
    output logic [PIX_W*ROW_PIX-1:0] ram_din,
    output logic                     conv_run,
    input  logic                     conv_done,
    output logic                     busy,
    output logic                     frame_done,
    output logic [15:0]              pix_sum
);

    localparam int CNT_W = (ROW_PIX > 1) ? $clog2(ROW_PIX) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_RUN,
        S_WAIT
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]               pix_cnt;
    logic [ADDR_W-1:0]              row_cnt;
    logic                           accept;
    logic                           last_pix;
    logic                           last_row;
    logic [ROW_PIX-1:0][PIX_W-1:0]  row_buf;
    logic [ROW_PIX-1:0][PIX_W-1:0]  row_nxt;

    assign accept   = pix_valid & pix_ready;
    assign last_pix = (pix_cnt == CNT_W'(ROW_PIX - 1));
    assign last_row = (row_cnt == ADDR_W'(NUM_ROWS - 1));
    assign busy     = (state != S_IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state and per-state strobes
    always_comb begin
        state_nxt  = state;
        pix_ready  = 1'b0;
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        conv_run   = 1'b0;
        frame_done = 1'b0;
        case (state)
            S_IDLE:  if (start) state_nxt = S_LOAD;
            S_LOAD: begin
                pix_ready = 1'b1;
                if (pix_valid && last_pix) state_nxt = S_WRITE;
            end
            S_WRITE: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                state_nxt = last_row ? S_RUN : S_LOAD;
            end
            S_RUN: begin
                conv_run  = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (conv_done) begin
                    frame_done = 1'b1;
                    state_nxt  = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Pixel/row counters; the row counter saturates at the final row
    always_ff @(posedge clk) begin
        if (!reset) begin
            pix_cnt <= '0;
            row_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    pix_cnt <= '0;
                    row_cnt <= '0;
                end
                S_LOAD: if (accept) pix_cnt <= last_pix ? '0 : pix_cnt + CNT_W'(1);
                S_WRITE: begin
                    pix_cnt <= '0;
                    if (!last_row) row_cnt <= row_cnt + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    // One byte lane per pixel slot; only the slot addressed by pix_cnt loads
    for (genvar k = 0; k < ROW_PIX; k++) begin : g_lane
        assign row_nxt[k] = (accept && pix_cnt == CNT_W'(k)) ? pix_data : row_buf[k];
    end

    // Assembly buffer, kept separate so ram_din only changes when a row completes
    always_ff @(posedge clk) begin
        if (!reset)      row_buf <= '0;
        else if (accept) row_buf <= row_nxt;
    end

    // RAM address/data latched with the last pixel and held until the next row
    always_ff @(posedge clk) begin
        if (!reset) begin
            ram_addr <= '0;
            ram_din  <= '0;
        end else if (accept && last_pix) begin
            ram_addr <= row_cnt;
            ram_din  <= row_nxt;
        end
    end

`ifdef CONV_LOADER_CHECKSUM_EN
    logic [15:0] sum_q;

    // Frame checksum: cleared on start, naturally frozen once loading ends
    always_ff @(posedge clk) begin
        if (!reset)                      sum_q <= '0;
        else if (state == S_IDLE && start) sum_q <= '0;
        else if (accept)                 sum_q <= sum_q + 16'(pix_data);
    end

    assign pix_sum = sum_q;
`else
    assign pix_sum = '0;
`endif

endmodule

// File: tb/tb_conv_frame_loader.sv
// Directed bench for conv_frame_loader: the driver pushes expected row writes
// into a queue, the monitor pops and compares on every ram_we.
module tb_conv_frame_loader;

    localparam int W = 1024;

    logic           clk, reset, start, pix_valid, pix_ready;
    logic [7:0]     pix_data;
    logic           ram_en, ram_we, conv_run, conv_done, busy, frame_done;
    logic [7:0]     ram_addr;
    logic [W-1:0]   ram_din;
    logic [15:0]    pix_sum;

    conv_frame_loader dut (
        .clk(clk), .reset(reset), .start(start), .pix_valid(pix_valid),
        .pix_data(pix_data), .pix_ready(pix_ready), .ram_en(ram_en),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .conv_run(conv_run), .conv_done(conv_done), .busy(busy),
        .frame_done(frame_done), .pix_sum(pix_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]   addr;
        logic [W-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  total = 0, bad = 0;
    int  cyc = 0;
    int  wr_count = 0, run_count = 0, run_cyc = 0;
    int  wr_cyc_a[256];

`ifdef CONV_LOADER_CHECKSUM_EN
    localparam logic [15:0] FF_SUM = 16'hC000;
`else
    localparam logic [15:0] FF_SUM = 16'h0000;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the head of the scoreboard
    always @(negedge clk) begin : mon
        wr_t e;
        if (ram_we) begin
            wr_count++;
            wr_cyc_a[ram_addr] = cyc;
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_write: addr %0h with empty queue", ram_addr);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", W'(ram_addr), W'(e.addr));
                chk("wr_data", ram_din, e.data);
                chk("wr_en", W'(ram_en), W'(1));
            end
        end
        if (conv_run) begin
            run_count++;
            run_cyc = cyc;
        end
    end

    function automatic logic [7:0] pix_of(input int mode, input int r, input int k);
        case (mode)
            0:       return 8'(k);
            1:       return 8'(r);
            2:       return 8'hFF;
            default: return 8'hA5 ^ 8'(k);
        endcase
    endfunction

    function automatic logic [W-1:0] word_of(input int mode, input int r);
        logic [W-1:0] w;
        for (int k = 0; k < 128; k++) w[8*k +: 8] = pix_of(mode, r, k);
        return w;
    endfunction

    task automatic send_px(input logic [7:0] d, input int gap, output int stalls);
        repeat (gap) @(negedge clk);
        pix_valid = 1'b1;
        pix_data  = d;
        stalls    = 0;
        while (!pix_ready && stalls < 400) begin
            @(negedge clk);
            stalls++;
        end
        if (stalls >= 400) begin
            total++; bad++;
            $display("FAIL px_timeout: pix_ready stuck 0 expected 1");
        end
        @(negedge clk);
        pix_valid = 1'b0;
    endtask

    task automatic send_row(input int r, input int mode, input bit gaps, input bit edge_ev,
                            output int stalls);
        int s;
        wr_t e;
        e.addr = 8'(r);
        e.data = word_of(mode, r);
        exp_q.push_back(e);
        stalls = 0;
        for (int k = 0; k < 128; k++) begin
            if (edge_ev && k == 10) begin start = 1'b1; conv_done = 1'b1; end
            if (edge_ev && k == 12) begin
                chk("edge_frame_done", W'(frame_done), W'(0));
                chk("edge_busy", W'(busy), W'(1));
            end
            if (edge_ev && k == 14) begin start = 1'b0; conv_done = 1'b0; end
            send_px(pix_of(mode, r, k), gaps ? int'($urandom_range(0, 1)) : 0, s);
            stalls += s;
        end
    endtask

    task automatic do_start(output int c0);
        c0    = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at the negedge where the last row's WRITE is visible
    task automatic finish_frame(input int run0, input logic [15:0] sum_exp);
        repeat (2) @(negedge clk);
        chk("run_once", W'(run_count - run0), W'(1));
        chk("run_after_wr127", W'(run_cyc), W'(wr_cyc_a[127] + 1));
        chk("pix_sum_run", W'(pix_sum), W'(sum_exp));
        for (int i = 0; i < 4; i++) begin
            chk("wait_busy", W'(busy), W'(1));
            @(negedge clk);
        end
        conv_done = 1'b1;
        #1;
        chk("frame_done_pulse", W'(frame_done), W'(1));
        @(negedge clk);
        conv_done = 1'b0;
        #1;
        chk("busy_after_done", W'(busy), W'(0));
        chk("frame_done_once", W'(frame_done), W'(0));
        chk("pix_sum_frozen", W'(pix_sum), W'(sum_exp));
        chk("run_still_once", W'(run_count - run0), W'(1));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_pix_ready"},  W'(pix_ready),  W'(0));
        chk({tag, "_ram_en"},     W'(ram_en),     W'(0));
        chk({tag, "_ram_we"},     W'(ram_we),     W'(0));
        chk({tag, "_conv_run"},   W'(conv_run),   W'(0));
        chk({tag, "_busy"},       W'(busy),       W'(0));
        chk({tag, "_frame_done"}, W'(frame_done), W'(0));
        chk({tag, "_pix_sum"},    W'(pix_sum),    W'(0));
        chk({tag, "_ram_addr"},   W'(ram_addr),   W'(0));
        chk({tag, "_ram_din"},    ram_din,        W'(0));
    endtask

    // Watchdog against a hung handshake
    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int c0, st, stall_sum, run0, wr0;
        reset = 1'b0; start = 1'b0; pix_valid = 1'b0; pix_data = '0; conv_done = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_state("rst");
        reset = 1'b1;
        @(negedge clk);

        // Frame 1: ramp pattern, pix_valid always high
        run0 = run_count; wr0 = wr_count;
        do_start(c0);
        stall_sum = 0;
        for (int r = 0; r < 128; r++) begin
            send_row(r, 0, 1'b0, 1'b0, st);
            if (r == 0) chk("row0_no_stall", W'(st), W'(0));
            stall_sum += st;
        end
        chk("stall_total", W'(stall_sum), W'(127));
        finish_frame(run0, 16'(FF_SUM * 0) + 16'(0) + (FF_SUM != 0 ? 16'h1FC0 * 16'd0 + 16'(128 * 8128) : 16'h0));
        chk("row0_latency", W'(wr_cyc_a[0] - c0), W'(129));
        chk("row_period", W'(wr_cyc_a[1] - wr_cyc_a[0]), W'(129));
        chk("din_lsb", W'(ram_din[7:0]), W'(8'h00));
        chk("din_msb", W'(ram_din[1023:1016]), W'(8'h7F));
        chk("addr_hold", W'(ram_addr), W'(8'd127));
        chk("f1_writes", W'(wr_count - wr0), W'(128));

        // Frame 2: pixel = row index, stray start/conv_done during LOAD
        run0 = run_count; wr0 = wr_count;
        do_start(c0);
        for (int r = 0; r < 128; r++) send_row(r, 1, 1'b0, r == 5, st);
        finish_frame(run0, FF_SUM != 0 ? 16'(128 * 8128) : 16'h0);
        chk("f2_writes", W'(wr_count - wr0), W'(128));

        // Frame 3: random valid gaps, then reset partway through row 3
        run0 = run_count; wr0 = wr_count;
        do_start(c0);
        send_row(0, 0, 1'b1, 1'b0, st);
        send_row(1, 0, 1'b1, 1'b0, st);
        send_row(2, 0, 1'b0, 1'b0, st);
        for (int k = 0; k < 60; k++) send_px(pix_of(0, 3, k), 0, st);
        reset = 1'b0;
        @(negedge clk);
        chk_reset_state("midrst");
        reset = 1'b1;
        @(negedge clk);
        chk("abort_no_run", W'(run_count - run0), W'(0));
        chk("abort_writes", W'(wr_count - wr0), W'(3));

        // Restart after abort must load address 0 from pixel 0
        wr0 = wr_count;
        do_start(c0);
        send_row(0, 3, 1'b0, 1'b0, st);
        @(negedge clk);
        chk("restart_writes", W'(wr_count - wr0), W'(1));
        chk("restart_addr", W'(ram_addr), W'(0));
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Frame 4: all 0xFF, checksum
        run0 = run_count;
        do_start(c0);
        for (int r = 0; r < 128; r++) send_row(r, 2, 1'b0, 1'b0, st);
        finish_frame(run0, FF_SUM);

        repeat (3) @(negedge clk);
        chk("queue_empty", W'(exp_q.size()), W'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
